// File: rtl/dma_channel_arbiter_if.sv
// Channel-side handshake bundle for the 8-channel DMA path arbiter.
// The channels drive master; the arbiter uses slave.
interface dma_channel_arbiter_if;
    logic [7:0] req;
    logic       beat;
    logic       last;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic [7:0] beat_cnt;

    modport master (output req, beat, last, input grant, sel, busy, beat_cnt);
    modport slave  (input req, beat, last, output grant, sel, busy, beat_cnt);
endinterface

// File: rtl/dma_channel_arbiter.sv
// Round-robin arbiter for one 32-bit transfer path shared by 8 DMA channels.
// A grant is held for a burst, then priority rotates past the released channel.
module dma_channel_arbiter #(
    parameter int unsigned MAX_BURST = 16
) (
    input logic                  clk,
    input logic                  reset,
    dma_channel_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_e;

    localparam logic [7:0] CAP = 8'(MAX_BURST - 1);

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] grant_q, grant_d;
    logic [7:0] cnt_q, cnt_d;

    logic       rel_last, rel_cap, rel_wd;
    logic [2:0] arb_ptr;
    logic [7:0] arb_req;
    logic [3:0] win;

    // Returns {found, index} of the first set request at or after p (mod 8).
    function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = '0;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        rel_last = bus.beat & bus.last;
        rel_cap  = bus.beat & (cnt_q == CAP);
        rel_wd   = ~bus.req[sel_q];
        arb_ptr  = ptr_q;
        arb_req  = bus.req;
        win      = '0;
        case (state_q)
            IDLE: begin
                win = pick(bus.req, ptr_q);
                if (win[3]) begin
                    state_d = BUSY;
                    sel_d   = win[2:0];
                    grant_d = 8'b1 << win[2:0];
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (rel_last | rel_cap | rel_wd) begin
                    arb_ptr = sel_q + 3'd1;
                    // A burst-capped channel stays eligible so a sole requester is regranted.
                    if (rel_last | rel_wd) arb_req[sel_q] = 1'b0;
                    ptr_d = arb_ptr;
                    win   = pick(arb_req, arb_ptr);
                    cnt_d = '0;
                    if (win[3]) begin
                        sel_d   = win[2:0];
                        grant_d = 8'b1 << win[2:0];
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (bus.beat) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.grant    = grant_q;
    assign bus.sel      = sel_q;
    assign bus.busy     = (state_q == BUSY);
    assign bus.beat_cnt = cnt_q;
endmodule
